// File: rtl/tartaruga_pkg.sv
// rtl/tartaruga_pkg.sv - shared types for the tartaruga pipeline hazard scoreboard
package tartaruga_pkg;

  localparam int SB_DEPTH = 3;
  localparam int SB_FW    = $clog2(SB_DEPTH + 1);

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       we;
    logic       is_load;
  } sb_entry_t;

  typedef logic [SB_FW-1:0] fwd_sel_t;

  localparam sb_entry_t SB_BUBBLE = '0;

  // x0 writes and non-writing entries never produce a dependency
  function automatic logic sb_rd_match(input sb_entry_t e, input logic [4:0] rs);
    return e.valid & e.we & (e.rd != 5'd0) & (e.rd == rs);
  endfunction

endpackage

// File: rtl/sb_match.sv
// rtl/sb_match.sv - compares one source register against the in-flight queue
// and reports the youngest matching stage and whether its result is ready.
module sb_match
  import tartaruga_pkg::*;
#(
  parameter int DEPTH         = 3,
  parameter int ALU_RDY_STAGE = 0,
  parameter int LD_RDY_STAGE  = 1,
  parameter int RF_BYPASS     = 0,
  localparam int FW           = $clog2(DEPTH + 1)
) (
  input  sb_entry_t [DEPTH-1:0] entries_i,
  input  logic [4:0]            rs_i,
  input  logic                  used_i,
  output logic                  hit_o,
  output logic                  ready_o,
  output logic [FW-1:0]         stage_o
);

  // a write-through regfile makes the WB stage invisible to decode
  localparam int LAST = (RF_BYPASS != 0) ? DEPTH - 2 : DEPTH - 1;

  // scan oldest to youngest so the lowest matching stage wins
  always_comb begin
    hit_o   = 1'b0;
    ready_o = 1'b0;
    stage_o = '0;
    for (int k = LAST; k >= 0; k--) begin
      if (used_i && sb_rd_match(entries_i[k], rs_i)) begin
        hit_o   = 1'b1;
        stage_o = FW'(k);
        ready_o = (k >= (entries_i[k].is_load ? LD_RDY_STAGE : ALU_RDY_STAGE));
      end
    end
  end

endmodule

// File: rtl/pipe_scoreboard.sv
// rtl/pipe_scoreboard.sv - in-order hazard tracker: issue/stall, flush squash and
// optional forwarding-source select (enabled by PIPE_SB_FWD_EN).
module pipe_scoreboard
  import tartaruga_pkg::*;
#(
  parameter int DEPTH         = 3,
  parameter int FLUSH_STAGE   = 0,
  parameter int ALU_RDY_STAGE = 0,
  parameter int LD_RDY_STAGE  = 1,
  parameter int RF_BYPASS     = 0,
  localparam int FW           = $clog2(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          rstn_i,
  input  logic          dec_valid_i,
  input  logic [4:0]    dec_rs1_i,
  input  logic [4:0]    dec_rs2_i,
  input  logic          dec_rs1_used_i,
  input  logic          dec_rs2_used_i,
  input  logic [4:0]    dec_rd_i,
  input  logic          dec_we_i,
  input  logic          dec_is_load_i,
  input  logic          exe_busy_i,
  input  logic          flush_i,
  output logic          issue_o,
  output logic          stall_o,
  output logic [FW-1:0] fwd_rs1_o,
  output logic [FW-1:0] fwd_rs2_o,
  output logic [FW-1:0] inflight_o
);

  sb_entry_t [DEPTH-1:0] sb_q, sb_d;
  logic [FW-1:0]         inflight_q, inflight_d;
  sb_entry_t             new_entry;

  logic          hit1, rdy1, hit2, rdy2;
  logic [FW-1:0] stg1, stg2;
  logic          haz1, haz2;

  sb_match #(
    .DEPTH(DEPTH), .ALU_RDY_STAGE(ALU_RDY_STAGE),
    .LD_RDY_STAGE(LD_RDY_STAGE), .RF_BYPASS(RF_BYPASS)
  ) u_match_rs1 (
    .entries_i(sb_q), .rs_i(dec_rs1_i), .used_i(dec_rs1_used_i),
    .hit_o(hit1), .ready_o(rdy1), .stage_o(stg1)
  );

  sb_match #(
    .DEPTH(DEPTH), .ALU_RDY_STAGE(ALU_RDY_STAGE),
    .LD_RDY_STAGE(LD_RDY_STAGE), .RF_BYPASS(RF_BYPASS)
  ) u_match_rs2 (
    .entries_i(sb_q), .rs_i(dec_rs2_i), .used_i(dec_rs2_used_i),
    .hit_o(hit2), .ready_o(rdy2), .stage_o(stg2)
  );

`ifdef PIPE_SB_FWD_EN
  assign haz1      = hit1 & ~rdy1;
  assign haz2      = hit2 & ~rdy2;
  assign fwd_rs1_o = (hit1 & rdy1) ? stg1 + 1'b1 : '0;
  assign fwd_rs2_o = (hit2 & rdy2) ? stg2 + 1'b1 : '0;
`else
  logic unused_fwd_info;
  assign unused_fwd_info = ^{rdy1, rdy2, stg1, stg2};
  assign haz1      = hit1;
  assign haz2      = hit2;
  assign fwd_rs1_o = '0;
  assign fwd_rs2_o = '0;
`endif

  // handshake reads idle while reset is held, whatever decode presents
  assign stall_o    = rstn_i & dec_valid_i & (haz1 | haz2 | exe_busy_i);
  assign issue_o    = rstn_i & dec_valid_i & ~stall_o & ~flush_i;
  assign inflight_o = inflight_q;

  assign new_entry = '{valid: 1'b1, rd: dec_rd_i, we: dec_we_i, is_load: dec_is_load_i};

  always_comb begin
    sb_d = sb_q;
    if (flush_i) begin
      // the flushing stage and everything younger are squashed as they advance
      sb_d[0] = SB_BUBBLE;
      for (int k = 1; k < DEPTH; k++) begin
        sb_d[k] = (k <= FLUSH_STAGE + 1) ? SB_BUBBLE : sb_q[k-1];
      end
    end else if (exe_busy_i) begin
      sb_d[0] = sb_q[0];
      for (int k = 1; k < DEPTH; k++) begin
        sb_d[k] = (k == 1) ? SB_BUBBLE : sb_q[k-1];
      end
    end else begin
      sb_d[0] = issue_o ? new_entry : SB_BUBBLE;
      for (int k = 1; k < DEPTH; k++) begin
        sb_d[k] = sb_q[k-1];
      end
    end
  end

  always_comb begin
    inflight_d = '0;
    for (int k = 0; k < DEPTH; k++) begin
      inflight_d = inflight_d + FW'(sb_d[k].valid);
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sb_q       <= '0;
      inflight_q <= '0;
    end else begin
      sb_q       <= sb_d;
      inflight_q <= inflight_d;
    end
  end

endmodule

// File: tb/tb_pipe_scoreboard.sv
// tb/tb_pipe_scoreboard.sv - scoreboard bench for pipe_scoreboard (DEPTH=3, FLUSH_STAGE=0,
// ALU_RDY_STAGE=0, LD_RDY_STAGE=1); forwarding vectors selected by PIPE_SB_FWD_EN.
module tb_pipe_scoreboard;

  logic       clk_i = 1'b0;
  logic       rstn_i;
  logic       dec_valid_i, dec_rs1_used_i, dec_rs2_used_i, dec_we_i, dec_is_load_i;
  logic [4:0] dec_rs1_i, dec_rs2_i, dec_rd_i;
  logic       exe_busy_i, flush_i;
  logic       issue_o, stall_o;
  logic [1:0] fwd_rs1_o, fwd_rs2_o, inflight_o;

  typedef struct packed {
    logic       issue;
    logic       stall;
    logic [1:0] f1;
    logic [1:0] f2;
    logic [1:0] inf;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;

  pipe_scoreboard dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .dec_valid_i(dec_valid_i), .dec_rs1_i(dec_rs1_i), .dec_rs2_i(dec_rs2_i),
    .dec_rs1_used_i(dec_rs1_used_i), .dec_rs2_used_i(dec_rs2_used_i),
    .dec_rd_i(dec_rd_i), .dec_we_i(dec_we_i), .dec_is_load_i(dec_is_load_i),
    .exe_busy_i(exe_busy_i), .flush_i(flush_i),
    .issue_o(issue_o), .stall_o(stall_o),
    .fwd_rs1_o(fwd_rs1_o), .fwd_rs2_o(fwd_rs2_o), .inflight_o(inflight_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, %0d expectations pending", exp_q.size());
    $fatal(1, "timeout");
  end

  // monitor: compares at the falling edge, away from the active edge
  always @(negedge clk_i) begin
    exp_t  e;
    string nm;
    if (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      n_tests++;
      if ({issue_o, stall_o, fwd_rs1_o, fwd_rs2_o, inflight_o} !== e) begin
        n_fail++;
        $display("FAIL %s: got issue=%0b stall=%0b fwd1=%0d fwd2=%0d inflight=%0d, expected issue=%0b stall=%0b fwd1=%0d fwd2=%0d inflight=%0d",
                 nm, issue_o, stall_o, fwd_rs1_o, fwd_rs2_o, inflight_o,
                 e.issue, e.stall, e.f1, e.f2, e.inf);
      end
    end
  end

  task automatic expect_out(input string nm, input logic ei, input logic es,
                            input logic [1:0] ef1, input logic [1:0] ef2, input logic [1:0] einf);
    exp_t e;
    e = '{issue: ei, stall: es, f1: ef1, f2: ef2, inf: einf};
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic step(input string nm, input logic v,
                      input logic [4:0] r1, input logic u1, input logic [4:0] r2, input logic u2,
                      input logic [4:0] rd, input logic we, input logic ld,
                      input logic busy, input logic fl,
                      input logic ei, input logic es, input logic [1:0] ef1,
                      input logic [1:0] ef2, input logic [1:0] einf);
    @(posedge clk_i);
    #1;
    dec_valid_i    = v;
    dec_rs1_i      = r1;
    dec_rs1_used_i = u1;
    dec_rs2_i      = r2;
    dec_rs2_used_i = u2;
    dec_rd_i       = rd;
    dec_we_i       = we;
    dec_is_load_i  = ld;
    exe_busy_i     = busy;
    flush_i        = fl;
    expect_out(nm, ei, es, ef1, ef2, einf);
  endtask

  task automatic idle(input string nm, input logic [1:0] einf);
    step(nm, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, einf);
  endtask

  initial begin
    rstn_i = 1'b0;
    dec_valid_i = 0; dec_rs1_i = 0; dec_rs2_i = 0; dec_rs1_used_i = 0; dec_rs2_used_i = 0;
    dec_rd_i = 0; dec_we_i = 0; dec_is_load_i = 0; exe_busy_i = 0; flush_i = 0;
    expect_out("reset", 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk_i);
    #2 rstn_i = 1'b1;

    // dependent ALU pair: addi x1 ; add x2,x1,x1
    step("t1_addi", 1, 0, 1, 0, 0, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0);
`ifdef PIPE_SB_FWD_EN
    step("t1_fwd", 1, 1, 1, 1, 1, 2, 1, 0, 0, 0, 1, 0, 1, 1, 1);
    idle("t1_drain0", 2); idle("t1_drain1", 2); idle("t1_drain2", 1);
    // load-use: lw x5 ; add x6,x5,x0
    step("t3_lw",    1, 0, 1, 0, 0, 5, 1, 1, 0, 0, 1, 0, 0, 0, 0);
    step("t3_stall", 1, 5, 1, 0, 1, 6, 1, 0, 0, 0, 0, 1, 0, 0, 1);
    step("t3_issue", 1, 5, 1, 0, 1, 6, 1, 0, 0, 0, 1, 0, 2, 0, 1);
    idle("t3_drain0", 2); idle("t3_drain1", 1); idle("t3_drain2", 1);
`else
    step("t1_stall_a", 1, 1, 1, 1, 1, 2, 1, 0, 0, 0, 0, 1, 0, 0, 1);
    step("t1_stall_b", 1, 1, 1, 1, 1, 2, 1, 0, 0, 0, 0, 1, 0, 0, 1);
    step("t1_stall_c", 1, 1, 1, 1, 1, 2, 1, 0, 0, 0, 0, 1, 0, 0, 1);
    step("t1_issue",   1, 1, 1, 1, 1, 2, 1, 0, 0, 0, 1, 0, 0, 0, 0);
    idle("t1_drain0", 1); idle("t1_drain1", 1); idle("t1_drain2", 1);
`endif

    // x0 destination and non-writing entries never hazard but are counted
    step("t4_x0_w",  1, 0, 1, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0);
    step("t4_nowe",  1, 0, 1, 0, 1, 3, 0, 0, 0, 0, 1, 0, 0, 0, 1);
    step("t4_read",  1, 0, 1, 3, 1, 4, 0, 0, 0, 0, 1, 0, 0, 0, 2);
    idle("t4_inf3", 3); idle("t4_inf2", 2); idle("t4_inf1", 1);

    // flush with producers x8 (stage 0) and x7 (stage 1)
    step("t5_a",     1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 1, 0, 0, 0, 0);
    step("t5_b",     1, 0, 0, 0, 0, 8, 1, 0, 0, 0, 1, 0, 0, 0, 1);
    step("t5_flush", 1, 0, 0, 0, 0, 9, 1, 0, 0, 1, 0, 0, 0, 0, 2);
`ifdef PIPE_SB_FWD_EN
    step("t5_probe", 1, 7, 1, 8, 1, 0, 0, 0, 0, 0, 1, 0, 3, 0, 1);
`else
    step("t5_probe", 1, 7, 1, 8, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1);
    step("t5_issue", 1, 7, 1, 8, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
`endif
    idle("t5_drain0", 1); idle("t5_drain1", 1); idle("t5_drain2", 1);

    // flush and exe_busy together: flush result wins
    step("t5b_a",     1, 0, 0, 0, 0, 10, 1, 0, 0, 0, 1, 0, 0, 0, 0);
    step("t5b_b",     1, 0, 0, 0, 0, 11, 1, 0, 0, 0, 1, 0, 0, 0, 1);
    step("t5b_fb",    1, 0, 0, 0, 0, 12, 1, 0, 1, 1, 0, 1, 0, 0, 2);
    idle("t5b_after", 1);

    // exe_busy holds x12 in stage 0 for two cycles
    step("t6_a",     1, 0, 0, 0, 0, 12, 1, 0, 0, 0, 1, 0, 0, 0, 0);
    step("t6_busy1", 1, 0, 0, 0, 0, 13, 1, 0, 1, 0, 0, 1, 0, 0, 1);
    step("t6_busy2", 1, 0, 0, 0, 0, 13, 1, 0, 1, 0, 0, 1, 0, 0, 1);
`ifdef PIPE_SB_FWD_EN
    step("t6_rd_fwd", 1, 12, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 1);
    step("t6_busy3",  1, 0, 0, 0, 0, 13, 1, 0, 1, 0, 0, 1, 0, 0, 2);
`else
    step("t6_rd_s0", 1, 12, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1);
    step("t6_rd_s1", 1, 12, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1);
    step("t6_rd_s2", 1, 12, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1);
    step("t6_rd_go", 1, 12, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    step("t6_busy3", 1, 0, 0, 0, 0, 13, 1, 0, 1, 0, 0, 1, 0, 0, 1);
`endif

    // asynchronous reset mid-cycle with busy decode still presented
    @(posedge clk_i);
    #2 rstn_i = 1'b0;
    expect_out("t6_async_rst", 0, 0, 0, 0, 0);
    @(negedge clk_i);
    #1;
    dec_valid_i = 0; exe_busy_i = 0; dec_we_i = 0;
    expect_out("rst_hold", 0, 0, 0, 0, 0);
    @(negedge clk_i);
    #2 rstn_i = 1'b1;
    idle("post_rst0", 0);
    idle("post_rst1", 0);

    repeat (2) @(negedge clk_i);
    #1;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
